// File: rtl/memory_turn_ctrl_pkg.sv
// Shared types and helpers for the memory-game turn controller.
package memory_pkg;

  localparam int         N_CARDS = 16;
  localparam int         SYM_W   = 3;
  localparam logic [7:0] NO_SEL  = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    PICK1,
    PICK2,
    SHOW,
    RESOLVE,
    DONE
  } turn_state_t;

  // Extract the symbol of card idx from the packed board vector.
  function automatic logic [SYM_W-1:0] sym_of(input logic [N_CARDS*SYM_W-1:0] board,
                                               input logic [7:0]               idx);
    logic [$clog2(N_CARDS)-1:0] k;
    k = idx[$clog2(N_CARDS)-1:0];
    return board[k*SYM_W +: SYM_W];
  endfunction

endpackage

// File: rtl/memory_turn_ctrl_cycle_timer.sv
// Free-running cycle counter with synchronous clear; tc_o pulses on the
// last cycle of a CYCLES-long count and the counter wraps to zero there.
module cycle_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal count and next count; clear has priority over counting.
  always_comb begin
    tc_o  = en_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/memory_turn_ctrl.sv
// One two-player turn of the 16-card memory game: two picks, symbol compare,
// reveal window, then commit the pair or flip the cards back.
module memory_turn_ctrl #(
  parameter int N_CARDS     = memory_pkg::N_CARDS,
  parameter int SYM_W       = memory_pkg::SYM_W,
  parameter int SHOW_CYCLES = 25_000_000,
  parameter int TURN_CYCLES = 500_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     pick_valid_i,
  input  logic [7:0]               pick_idx_i,
  input  logic [N_CARDS*SYM_W-1:0] board_sym_i,
  output logic [7:0]               selected1_o,
  output logic [7:0]               selected2_o,
  output logic                     par_o,
  output logic [N_CARDS-1:0]       matched_o,
  output logic                     player_o,
  output logic [3:0]               score0_o,
  output logic [3:0]               score1_o,
  output logic                     game_over_o
);

  import memory_pkg::*;

  localparam int         IDX_W     = $clog2(N_CARDS);
  localparam logic [7:0] N_CARDS_B = 8'(N_CARDS);
  localparam logic [3:0] SCORE_MAX = 4'(N_CARDS / 2);
  localparam logic [N_CARDS-1:0] ONE_HOT0 = {{(N_CARDS-1){1'b0}}, 1'b1};

  // Saturating score increment: a player can never own more than all pairs.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? s : s + 4'd1;
  endfunction

  turn_state_t        state_q, state_d;
  logic [7:0]         sel1_q, sel1_d, sel2_q, sel2_d;
  logic [N_CARDS-1:0] matched_q, matched_d;
  logic [N_CARDS-1:0] pair_mask, resolved_matched;
  logic               player_q, player_d;
  logic [3:0]         score0_q, score0_d, score1_q, score1_d;
  logic               pair_hit_q, pair_hit_d;
  logic               in_pick, pick_ok, turn_clr, turn_tc;
  logic               show_en, show_clr, show_tc;

  // Pick legality: in range, not yet matched, and not the card already picked.
  always_comb begin
    in_pick = (state_q == PICK1) || (state_q == PICK2);
    pick_ok = 1'b0;
    if (in_pick && pick_valid_i && (pick_idx_i < N_CARDS_B)) begin
      pick_ok = !matched_q[pick_idx_i[IDX_W-1:0]] &&
                !((state_q == PICK2) && (pick_idx_i == sel1_q));
    end
  end

  // Matched set as it will look after a successful resolve.
  always_comb begin
    pair_mask        = (ONE_HOT0 << sel1_q[IDX_W-1:0]) | (ONE_HOT0 << sel2_q[IDX_W-1:0]);
    resolved_matched = pair_hit_q ? (matched_q | pair_mask) : matched_q;
  end

  assign turn_clr = pick_ok || !in_pick;
  assign show_en  = (state_q == SHOW);
  assign show_clr = (state_q != SHOW);

  cycle_timer #(.CYCLES(TURN_CYCLES)) u_turn_timer (
    .clk  (clk),
    .rst  (rst),
    .en_i (in_pick),
    .clr_i(turn_clr),
    .tc_o (turn_tc)
  );

  cycle_timer #(.CYCLES(SHOW_CYCLES)) u_show_timer (
    .clk  (clk),
    .rst  (rst),
    .en_i (show_en),
    .clr_i(show_clr),
    .tc_o (show_tc)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; a legal pick beats a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start_i) state_d = PICK1;
      PICK1:      if (pick_ok) state_d = PICK2;
      PICK2: begin
        if (pick_ok)      state_d = SHOW;
        else if (turn_tc) state_d = PICK1;
      end
      SHOW:       if (show_tc) state_d = RESOLVE;
      RESOLVE:    state_d = (&resolved_matched) ? DONE : PICK1;
      default:    state_d = IDLE;
    endcase
  end

  // FSM outputs: cards flip back only during a mismatch reveal.
  always_comb begin
    par_o       = !((state_q == SHOW) && !pair_hit_q);
    game_over_o = (state_q == DONE);
  end

  // Turn datapath: selections, compare result, matched set, player and scores.
  always_comb begin
    sel1_d     = sel1_q;
    sel2_d     = sel2_q;
    pair_hit_d = pair_hit_q;
    matched_d  = matched_q;
    player_d   = player_q;
    score0_d   = score0_q;
    score1_d   = score1_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          sel1_d     = NO_SEL;
          sel2_d     = NO_SEL;
          pair_hit_d = 1'b0;
          matched_d  = '0;
          player_d   = 1'b0;
          score0_d   = '0;
          score1_d   = '0;
        end
      end
      PICK1, PICK2: begin
        if (pick_ok) begin
          if (state_q == PICK1) begin
            sel1_d = pick_idx_i;
          end else begin
            sel2_d     = pick_idx_i;
            pair_hit_d = (sym_of(board_sym_i, pick_idx_i) == sym_of(board_sym_i, sel1_q));
          end
        end else if (turn_tc) begin
          sel1_d   = NO_SEL;
          sel2_d   = NO_SEL;
          player_d = !player_q;
        end
      end
      RESOLVE: begin
        sel1_d = NO_SEL;
        sel2_d = NO_SEL;
        if (pair_hit_q) begin
          matched_d = resolved_matched;
          if (player_q) score1_d = sat_inc(score1_q);
          else          score0_d = sat_inc(score0_q);
        end else begin
          player_d = !player_q;
        end
      end
      default: ;
    endcase
  end

  // Turn datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel1_q     <= NO_SEL;
      sel2_q     <= NO_SEL;
      pair_hit_q <= 1'b0;
      matched_q  <= '0;
      player_q   <= 1'b0;
      score0_q   <= '0;
      score1_q   <= '0;
    end else begin
      sel1_q     <= sel1_d;
      sel2_q     <= sel2_d;
      pair_hit_q <= pair_hit_d;
      matched_q  <= matched_d;
      player_q   <= player_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
    end
  end

  assign selected1_o = sel1_q;
  assign selected2_o = sel2_q;
  assign matched_o   = matched_q;
  assign player_o    = player_q;
  assign score0_o    = score0_q;
  assign score1_o    = score1_q;

endmodule
